milano_imem: RTL and testbench

Instruction-memory responder for the milano core's fetch interface. It accepts the core's word fetch address and fetch enable, and returns instruction data with a fixed one-cycle latency. It flags misaligned and out-of-range fetches. A byte-enabled loader write port fills the memory before or between fetches. It sits between the core top and the system bus/boot logic, in place of a behavioural RAM model.

---
 rtl/milano_pkg.sv | 18 +
 rtl/milano_imem_if.sv | 31 +++
 rtl/imem_bank.sv | 32 +++
 rtl/milano_imem.sv | 93 +++++++++
 tb/tb_milano_imem.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/milano_pkg.sv
`default_nettype none
// ==========================================================================
// milano_pkg : shared constants and types for the milano instruction memory
// Revision   : 1.0
// ==========================================================================
package milano_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Registered response state that drives rvalid/err.
  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_OK   = 2'd1,
    IMEM_ERR  = 2'd2
  } imem_resp_e;

endpackage
`default_nettype wire

// File: rtl/milano_imem_if.sv
`default_nettype none
// ==========================================================================
// milano_imem_if : core fetch port and loader write port of the imem
// Revision       : 1.0
// ==========================================================================
interface milano_imem_if;

  logic        fetch_enable_i;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic        instr_rvalid_o;
  logic        instr_err_o;
  logic        load_req_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_wdata_i;
  logic [3:0]  load_be_i;
  logic        load_gnt_o;
  logic [15:0] err_count_o;

  modport master (
    output fetch_enable_i, instr_addr_i, load_req_i, load_addr_i, load_wdata_i, load_be_i,
    input  instr_rdata_o, instr_rvalid_o, instr_err_o, load_gnt_o, err_count_o
  );

  modport slave (
    input  fetch_enable_i, instr_addr_i, load_req_i, load_addr_i, load_wdata_i, load_be_i,
    output instr_rdata_o, instr_rvalid_o, instr_err_o, load_gnt_o, err_count_o
  );

endinterface
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// ==========================================================================
// imem_bank : synchronous single-port word array with byte write enables
// Revision  : 1.0
// ==========================================================================
module imem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  input  logic             re,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read data register only updates on a read, so it holds between fetches.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/milano_imem.sv
`default_nettype none
// ==========================================================================
// milano_imem : one-cycle-latency instruction memory with loader write port
// Revision    : 1.0
// ==========================================================================
module milano_imem
  import milano_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  milano_imem_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

  logic [31:0]      fetch_off;
  logic [31:0]      load_off;
  logic             fetch_ok;
  logic             load_gnt;
  logic             load_we;
  logic [IDX_W-1:0] bank_addr;
  logic [31:0]      bank_rdata;
  imem_resp_e       resp_q;
  imem_resp_e       resp_d;
  logic             bank_sel_q;
  logic [15:0]      err_cnt_q;

  // Offsets wrap, so addresses below BASE_ADDR land far out of range.
  assign fetch_off = bus.instr_addr_i - BASE_ADDR;
  assign load_off  = bus.load_addr_i - BASE_ADDR;
  assign fetch_ok  = bus.fetch_enable_i & (bus.instr_addr_i[1:0] == 2'b00) & (fetch_off < SPAN);

  assign load_gnt  = bus.load_req_i & ~bus.fetch_enable_i;
  assign load_we   = load_gnt & (load_off < SPAN);
  assign bank_addr = bus.fetch_enable_i ? fetch_off[IDX_W+1:2] : load_off[IDX_W+1:2];

  imem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk   (clk_i),
    .addr  (bank_addr),
    .re    (fetch_ok),
    .we    (load_we),
    .be    (bus.load_be_i),
    .wdata (bus.load_wdata_i),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) resp_q <= IMEM_IDLE;
    else         resp_q <= resp_d;
  end

  always_comb begin
    resp_d = IMEM_IDLE;
    if (bus.fetch_enable_i) resp_d = fetch_ok ? IMEM_OK : IMEM_ERR;
  end

  always_comb begin
    bus.instr_rvalid_o = (resp_q != IMEM_IDLE);
    bus.instr_err_o    = (resp_q == IMEM_ERR);
  end

  // Remembers whether the latest response came from the array or was a NOP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_sel_q <= 1'b0;
    end else if (resp_d == IMEM_OK) begin
      bank_sel_q <= 1'b1;
    end else if (resp_d == IMEM_ERR) begin
      bank_sel_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 16'd0;
    end else if ((resp_q == IMEM_ERR) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.instr_rdata_o = bank_sel_q ? bank_rdata : INSTR_NOP;
  assign bus.load_gnt_o    = load_gnt;
  assign bus.err_count_o   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_milano_imem.sv
`default_nettype none
// ==========================================================================
// tb_milano_imem : directed plus randomized checks against a reference model
// Revision       : 1.0
// ==========================================================================
module tb_milano_imem;
  import milano_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] SPAN  = 32'd64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  milano_imem_if bus_if();

  milano_imem #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_rdata;
  logic        exp_rvalid;
  logic        exp_err;
  logic [15:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rdata"},  bus_if.instr_rdata_o, exp_rdata);
    check({tag, "_rvalid"}, {31'd0, bus_if.instr_rvalid_o}, {31'd0, exp_rvalid});
    check({tag, "_err"},    {31'd0, bus_if.instr_err_o}, {31'd0, exp_err});
    check({tag, "_cnt"},    {16'd0, bus_if.err_count_o}, {16'd0, exp_cnt});
  endtask

  task automatic model_reset();
    exp_rdata  = INSTR_NOP;
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    exp_cnt    = 16'd0;
  endtask

  // One clock cycle: drive on negedge, check grant, advance model at posedge, check outputs.
  task automatic cyc(input logic fe, input logic [31:0] fa, input logic lr,
                     input logic [31:0] la, input logic [31:0] wd, input logic [3:0] be,
                     input string tag);
    logic [31:0] off;
    @(negedge clk);
    bus_if.fetch_enable_i = fe;
    bus_if.instr_addr_i   = fa;
    bus_if.load_req_i     = lr;
    bus_if.load_addr_i    = la;
    bus_if.load_wdata_i   = wd;
    bus_if.load_be_i      = be;
    #1;
    check({tag, "_gnt"}, {31'd0, bus_if.load_gnt_o}, {31'd0, lr & ~fe});
    @(posedge clk);
    if (exp_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    if (fe) begin
      off        = fa - BASE;
      exp_rvalid = 1'b1;
      if (fa[1:0] == 2'b00 && off < SPAN) begin
        exp_rdata = mem_m[off[5:2]];
        exp_err   = 1'b0;
      end else begin
        exp_rdata = INSTR_NOP;
        exp_err   = 1'b1;
      end
    end else begin
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      if (lr) begin
        off = la - BASE;
        if (off < SPAN) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_m[off[5:2]][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
    end
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1:    return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      2:       return BASE + 32'($urandom_range(0, 63));
      3:       return BASE - 32'(4 * $urandom_range(1, 8));
      4:       return BASE + SPAN + 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus_if.fetch_enable_i = 1'b0;
    bus_if.instr_addr_i   = 32'd0;
    bus_if.load_req_i     = 1'b1;
    bus_if.load_addr_i    = BASE;
    bus_if.load_wdata_i   = 32'd0;
    bus_if.load_be_i      = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset_gnt", {31'd0, bus_if.load_gnt_o}, 32'd1);
    bus_if.load_req_i = 1'b0;
    rst_n = 1'b1;

    cyc(0, 0, 0, 0, 0, 4'h0, "idle");
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, BASE + 32'(4 * i), $urandom, 4'hF, "fill");

    cyc(0, 0, 1, BASE + 32'h8, 32'h0050_0093, 4'hF, "ld8");
    cyc(1, BASE + 32'h8, 0, 0, 0, 4'h0, "fetch8");
    check("fetch8_const", bus_if.instr_rdata_o, 32'h0050_0093);

    cyc(0, 0, 1, BASE, 32'hAABB_CCDD, 4'hF, "ld0");
    cyc(0, 0, 1, BASE + 32'h2, 32'h1122_3344, 4'b0101, "ld0_be");
    cyc(1, BASE, 0, 0, 0, 4'h0, "fetch0");
    check("fetch0_const", bus_if.instr_rdata_o, 32'hAA22_CC44);

    cyc(1, BASE + 32'h6, 0, 0, 0, 4'h0, "misalign");
    cyc(1, BASE + SPAN, 0, 0, 0, 4'h0, "oor");
    cyc(0, 0, 0, 0, 0, 4'h0, "after_err");
    check("errcnt_const", {16'd0, bus_if.err_count_o}, 32'd2);

    for (int i = 0; i < 3; i++) cyc(1, BASE + 32'hC, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, "hold");
    cyc(0, 0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, "hold_drop");
    cyc(1, BASE + 32'h10, 0, 0, 0, 4'h0, "hold_fetch");
    check("hold_const", bus_if.instr_rdata_o, 32'hDEAD_BEEF);

    cyc(0, 0, 1, BASE - 32'h4, 32'h0BAD_0BAD, 4'hF, "ld_oor");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1)
        cyc(1, pick_addr(), $urandom_range(0, 1) == 1, pick_addr(), $urandom, 4'($urandom), "rnd");
      else
        cyc(0, 0, $urandom_range(0, 1) == 1, pick_addr(), $urandom, 4'($urandom), "rnd");
    end

    cyc(1, BASE, 0, 0, 0, 4'h0, "pre_rst0");
    cyc(1, BASE + SPAN + 32'h4, 0, 0, 0, 4'h0, "pre_rst1");
    @(negedge clk);
    bus_if.instr_addr_i = BASE + 32'h4;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    @(negedge clk);
    bus_if.fetch_enable_i = 1'b0;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 4'h0, "post_rst_idle");
    for (int i = 0; i < DEPTH; i++) cyc(1, BASE + 32'(4 * i), 0, 0, 0, 4'h0, "post_rst");
    cyc(0, 0, 0, 0, 0, 4'h0, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
